// File: rtl/serial_byte_capture_if.sv
// serial_byte_capture_if
//   Groups the serial-side inputs and the parallel-side results of the
//   serial byte capture block.
//   master : producer of iData/iSelect, consumer of the results.
//   slave  : the capture block itself.
//   Signals:
//     iData        serial data bit (asynchronous to the capture clock)
//     iSelect[2:0] bit index accompanying iData (asynchronous, may glitch)
//     oByte[7:0]   last completed word
//     oValid       one-cycle pulse when oByte updates
//     oSeqErr      one-cycle pulse on an out-of-order index
//     oErrCount    saturating sequence-error count
//     oFrameCount  wrapping completed-frame count
//     oBusy        high while a frame is being collected
interface serial_byte_capture_if;
   logic       iData;
   logic [2:0] iSelect;
   logic [7:0] oByte;
   logic       oValid;
   logic       oSeqErr;
   logic [7:0] oErrCount;
   logic [7:0] oFrameCount;
   logic       oBusy;

   modport master (
      output iData, iSelect,
      input  oByte, oValid, oSeqErr, oErrCount, oFrameCount, oBusy
   );

   modport slave (
      input  iData, iSelect,
      output oByte, oValid, oSeqErr, oErrCount, oFrameCount, oBusy
   );
endinterface

// File: rtl/serial_byte_capture.sv
// serial_byte_capture
//   Rebuilds an 8-bit word from a slow serial bit plus its 3-bit index.
//   Both inputs are resynchronised, the index is glitch-filtered, and each
//   stable index is accepted exactly once. Indices must arrive 0..7 in order;
//   out-of-order indices are counted as sequence errors, complete frames are
//   counted and presented on oByte with a one-cycle oValid strobe.
//   Ports:
//     iClk    system clock, all state on posedge
//     iRst_n  asynchronous active-low reset
//     bus     serial_byte_capture_if.slave (iData/iSelect in, results out)
//   Parameters:
//     STABLE  synced cycles an index must hold before acceptance (1..15)
//     TIMEOUT cycles without an accept while collecting before the partial
//             frame is dropped (>= 2)
module serial_byte_capture #(
   parameter int STABLE  = 4,
   parameter int TIMEOUT = 100000000
) (
   input  logic                  iClk,
   input  logic                  iRst_n,
   serial_byte_capture_if.slave  bus
);

   localparam int                TMO_W    = $clog2(TIMEOUT);
   localparam logic [3:0]        STABLE_C = 4'(STABLE);
   localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(TIMEOUT - 1);
   localparam logic [TMO_W-1:0]  TMO_ONE  = TMO_W'(1);

   typedef enum logic {
      HUNT    = 1'b0,
      COLLECT = 1'b1
   } state_t;

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   // p0/p1: two-flop synchronisers; p2: previous synced value, used both for
   // change detection and as the value the stability counter describes.
   logic [2:0] sel_p0, sel_p1, sel_p2;
   logic       data_p0, data_p1, data_p2;
   logic [3:0] stab_cnt;
   logic [2:0] last_sel;
   logic       last_vld;
   logic       accept;

   // stab_cnt is the run length of the value now in sel_p2, so the accepted
   // index and bit come from the p2 stage.
   assign accept = (stab_cnt == STABLE_C) && (!last_vld || (sel_p2 != last_sel));

   always_ff @(posedge iClk or negedge iRst_n) begin
      if (!iRst_n) begin
         sel_p0   <= '0;
         sel_p1   <= '0;
         sel_p2   <= '0;
         data_p0  <= 1'b0;
         data_p1  <= 1'b0;
         data_p2  <= 1'b0;
         stab_cnt <= '0;
         last_sel <= '0;
         last_vld <= 1'b0;
      end else begin
         sel_p0  <= bus.iSelect;
         sel_p1  <= sel_p0;
         sel_p2  <= sel_p1;
         data_p0 <= bus.iData;
         data_p1 <= data_p0;
         data_p2 <= data_p1;
         if (sel_p1 != sel_p2)
            stab_cnt <= 4'd1;
         else if (stab_cnt != STABLE_C)
            stab_cnt <= stab_cnt + 4'd1;
         if (accept) begin
            last_sel <= sel_p2;
            last_vld <= 1'b1;
         end
      end
   end

   // Frame assembly state machine
   state_t           state, state_nxt;
   logic [2:0]       expected, expected_nxt;
   logic [7:0]       asm_bits, asm_nxt;
   logic [7:0]       frame_bits;
   logic [TMO_W-1:0] tmo_cnt, tmo_nxt;
   logic [7:0]       byte_r, byte_nxt;
   logic             valid_r, valid_nxt;
   logic             seqerr_r, seqerr_nxt;
   logic [7:0]       errcnt_r, errcnt_nxt;
   logic [7:0]       framecnt_r, framecnt_nxt;

   always_ff @(posedge iClk or negedge iRst_n) begin
      if (!iRst_n) begin
         state      <= HUNT;
         expected   <= '0;
         asm_bits   <= '0;
         tmo_cnt    <= '0;
         byte_r     <= '0;
         valid_r    <= 1'b0;
         seqerr_r   <= 1'b0;
         errcnt_r   <= '0;
         framecnt_r <= '0;
      end else begin
         state      <= state_nxt;
         expected   <= expected_nxt;
         asm_bits   <= asm_nxt;
         tmo_cnt    <= tmo_nxt;
         byte_r     <= byte_nxt;
         valid_r    <= valid_nxt;
         seqerr_r   <= seqerr_nxt;
         errcnt_r   <= errcnt_nxt;
         framecnt_r <= framecnt_nxt;
      end
   end

   always_comb begin
      state_nxt    = state;
      expected_nxt = expected;
      asm_nxt      = asm_bits;
      tmo_nxt      = tmo_cnt;
      byte_nxt     = byte_r;
      valid_nxt    = 1'b0;
      seqerr_nxt   = 1'b0;
      errcnt_nxt   = errcnt_r;
      framecnt_nxt = framecnt_r;
      frame_bits   = asm_bits;
      frame_bits[sel_p2] = data_p2;

      case (state)
         HUNT: begin
            tmo_nxt = '0;
            if (accept && (sel_p2 == 3'd0)) begin
               asm_nxt      = {7'b0, data_p2};
               expected_nxt = 3'd1;
               state_nxt    = COLLECT;
            end
         end
         COLLECT: begin
            // An accept always takes priority over an expiring timeout.
            if (accept) begin
               tmo_nxt = '0;
               if (sel_p2 == expected) begin
                  asm_nxt      = frame_bits;
                  expected_nxt = expected + 3'd1;
                  if (sel_p2 == 3'd7) begin
                     byte_nxt     = frame_bits;
                     valid_nxt    = 1'b1;
                     framecnt_nxt = framecnt_r + 8'd1;
                     state_nxt    = HUNT;
                  end
               end else begin
                  seqerr_nxt = 1'b1;
                  errcnt_nxt = sat_inc8(errcnt_r);
                  if (sel_p2 == 3'd0) begin
                     asm_nxt      = {7'b0, data_p2};
                     expected_nxt = 3'd1;
                  end else begin
                     asm_nxt   = '0;
                     state_nxt = HUNT;
                  end
               end
            end else if (tmo_cnt == TMO_LAST) begin
               tmo_nxt   = '0;
               asm_nxt   = '0;
               state_nxt = HUNT;
            end else begin
               tmo_nxt = tmo_cnt + TMO_ONE;
            end
         end
         default: state_nxt = HUNT;
      endcase
   end

   assign bus.oByte       = byte_r;
   assign bus.oValid      = valid_r;
   assign bus.oSeqErr     = seqerr_r;
   assign bus.oErrCount   = errcnt_r;
   assign bus.oFrameCount = framecnt_r;
   assign bus.oBusy       = (state == COLLECT);

endmodule
